// File: rtl/fast_circle_fetch_pkg.sv
// fast_pkg: shared FSM states and radius-3 circle offsets for the circle fetcher
package fast_pkg;
    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_t;
    localparam int NUM_PTS = 17;
    localparam int CIRCLE_R = 3;
    localparam logic signed [2:0] CIRCLE_DX [NUM_PTS] = '{
        3'sd0, 3'sd0, 3'sd1, 3'sd2, 3'sd3, 3'sd3, 3'sd3, 3'sd2, 3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1};
    localparam logic signed [2:0] CIRCLE_DY [NUM_PTS] = '{
        3'sd0, -3'sd3, -3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2, 3'sd3,
        3'sd3, 3'sd3, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2, -3'sd3};
endpackage

// File: rtl/fast_circle_fetch_if.sv
// fast_circle_fetch_if: single-port image SRAM bus between the fetcher and sram_image
interface fast_circle_fetch_if #(
    parameter int XW = 9,
    parameter int YW = 9,
    parameter int PD = 8
);
    logic [XW-1:0] x_addr;
    logic [YW-1:0] y_addr;
    logic ren;
    logic wen;
    logic [PD-1:0] wdat;
    logic [PD-1:0] rdat;
    modport master (output x_addr, y_addr, ren, wen, wdat, input rdat);
    modport slave (input x_addr, y_addr, ren, wen, wdat, output rdat);
endinterface

// File: rtl/fast_circle_fetch_rom.sv
// fast_circle_rom: point index to signed circle offset; indices past the circle map to the centre
module fast_circle_rom
    import fast_pkg::*;
(
    input  logic [4:0]        k,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy
);
    assign dx = (k < 5'(NUM_PTS)) ? CIRCLE_DX[k] : 3'sd0;
    assign dy = (k < 5'(NUM_PTS)) ? CIRCLE_DY[k] : 3'sd0;
endmodule

// File: rtl/fast_circle_fetch.sv
// fast_circle_fetch: fetches centre plus 16-point radius-3 circle from sram_image, yielding to loader writes
module fast_circle_fetch
    import fast_pkg::*;
#(
    parameter int X_MAX = 200,
    parameter int Y_MAX = 200,
    parameter int PIXEL_DEPTH = 8,
    localparam int XW = $clog2(X_MAX) + 1,
    localparam int YW = $clog2(Y_MAX) + 1
)(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [XW-1:0]          cx,
    input  logic [YW-1:0]          cy,
    output logic                   busy,
    output logic                   done,
    output logic                   oob,
    output logic                   pix_valid,
    output logic [4:0]             pix_idx,
    output logic [PIXEL_DEPTH-1:0] pix_data,
    input  logic                   wr_req,
    input  logic [XW-1:0]          wr_x,
    input  logic [YW-1:0]          wr_y,
    input  logic [PIXEL_DEPTH-1:0] wr_data,
    output logic                   wr_gnt,
    fast_circle_fetch_if.master    sram
);
    state_t state, state_nxt;
    logic [XW-1:0] cx_q;
    logic [YW-1:0] cy_q;
    logic [4:0] k, k_nxt;
    logic issue, at_edge;
    logic signed [2:0] dx, dy;
    logic signed [XW:0] px;
    logic signed [YW:0] py;

    fast_circle_rom u_rom (.k(k), .dx(dx), .dy(dy));

    assign at_edge = cx_q < XW'(CIRCLE_R) || cy_q < YW'(CIRCLE_R) ||
                     cx_q > XW'(X_MAX - CIRCLE_R - 1) || cy_q > YW'(Y_MAX - CIRCLE_R - 1);
    assign issue = state == ISSUE && !wr_req;
    assign px = $signed({1'b0, cx_q}) + (XW+1)'(dx);
    assign py = $signed({1'b0, cy_q}) + (YW+1)'(dy);
    // The loader owns the port whenever it asks; reads only fill the gaps, so ren and wen never overlap
    assign wr_gnt = wr_req;
    assign sram.wen = wr_req;
    assign sram.wdat = wr_req ? wr_data : '0;
    assign sram.ren = issue;
    assign sram.x_addr = wr_req ? wr_x : issue ? XW'(px) : '0;
    assign sram.y_addr = wr_req ? wr_y : issue ? YW'(py) : '0;
    assign pix_data = pix_valid ? sram.rdat : '0;

    // Next state and point counter; k only advances on cycles that actually read
    always_comb begin
        state_nxt = state;
        k_nxt = k;
        case (state)
            IDLE: state_nxt = start ? CHECK : IDLE;
            CHECK: begin
                state_nxt = at_edge ? IDLE : ISSUE;
                k_nxt = '0;
            end
            ISSUE: begin
                k_nxt = issue ? k + 5'd1 : k;
                state_nxt = (issue && k == 5'(NUM_PTS - 1)) ? DRAIN : ISSUE;
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, captured centre and registered status outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            k <= '0;
            cx_q <= '0;
            cy_q <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            oob <= 1'b0;
            pix_valid <= 1'b0;
            pix_idx <= '0;
        end else begin
            state <= state_nxt;
            k <= k_nxt;
            if (state == IDLE && start) begin
                cx_q <= cx;
                cy_q <= cy;
            end
            busy <= state_nxt != IDLE;
            done <= (state == CHECK && at_edge) || (issue && k == 5'(NUM_PTS - 1));
            oob <= state == CHECK && at_edge;
            pix_valid <= issue;
            if (issue) pix_idx <= k;
        end
    end
endmodule
